// File: rtl/sram_arbiter_if.sv
// Bus between two single-word requesters, the arbiter and a sync_sram.
// Ports: req/we/addr/wdata per requester, gnt/ack/rdata/busy back, ss_* strobes to the SRAM.
interface sram_arbiter_if #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 16
);
    logic              req0;
    logic              we0;
    logic [ADDR_W-1:0] addr0;
    logic [DATA_W-1:0] wdata0;
    logic              req1;
    logic              we1;
    logic [ADDR_W-1:0] addr1;
    logic [DATA_W-1:0] wdata1;
    logic [1:0]        gnt;
    logic [1:0]        ack;
    logic [DATA_W-1:0] rdata;
    logic              busy;
    logic              ss_cs;
    logic              ss_we;
    logic              ss_oe;
    logic [ADDR_W-1:0] ss_address;
    logic [DATA_W-1:0] ss_data_in;
    logic [DATA_W-1:0] ss_data_out;

    modport slave (
        input  req0, we0, addr0, wdata0,
        input  req1, we1, addr1, wdata1,
        input  ss_data_out,
        output gnt, ack, rdata, busy,
        output ss_cs, ss_we, ss_oe, ss_address, ss_data_in
    );

    modport master (
        output req0, we0, addr0, wdata0,
        output req1, we1, addr1, wdata1,
        output ss_data_out,
        input  gnt, ack, rdata, busy,
        input  ss_cs, ss_we, ss_oe, ss_address, ss_data_in
    );
endinterface

// File: rtl/sram_arbiter.sv
// Two-requester round-robin arbiter in front of one sync_sram.
// Ports: clk, reset (sync, active high), bus (slave side of sram_arbiter_if).
module sram_arbiter #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 16
) (
    input  logic           clk,
    input  logic           reset,
    sram_arbiter_if.slave  bus
);
    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACCESS = 2'd1;
    localparam logic [1:0] S_LATCH  = 2'd2;
    localparam logic [1:0] S_ACK    = 2'd3;

    logic [1:0]        r_state;
    logic              r_ptr;
    logic              r_op;
    logic              r_owner;
    logic [1:0]        r_gnt;
    logic [1:0]        r_ack;
    logic [DATA_W-1:0] r_rdata;
    logic              r_busy;
    logic              r_cs;
    logic              r_we;
    logic              r_oe;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_din;

    logic              w_any;
    logic              w_win;
    logic              w_we;
    logic [ADDR_W-1:0] w_addr;
    logic [DATA_W-1:0] w_din;

    // A lone requester wins outright; the pointer only breaks ties.
    assign w_any  = bus.req0 | bus.req1;
    assign w_win  = (bus.req0 & bus.req1) ? r_ptr : bus.req1;
    assign w_we   = w_win ? bus.we1    : bus.we0;
    assign w_addr = w_win ? bus.addr1  : bus.addr0;
    assign w_din  = w_win ? bus.wdata1 : bus.wdata0;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_ptr   <= 1'b0;
            r_op    <= 1'b0;
            r_owner <= 1'b0;
            r_gnt   <= 2'b00;
            r_ack   <= 2'b00;
            r_rdata <= '0;
            r_busy  <= 1'b0;
            r_cs    <= 1'b1;
            r_we    <= 1'b1;
            r_oe    <= 1'b1;
            r_addr  <= '0;
            r_din   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_any) begin
                        r_owner <= w_win;
                        r_op    <= w_we;
                        r_addr  <= w_addr;
                        r_din   <= w_din;
                        r_gnt   <= w_win ? 2'b10 : 2'b01;
                        r_busy  <= 1'b1;
                        // Strobes are registered, so they go active
                        // for exactly the ACCESS cycle.
                        r_cs    <= 1'b0;
                        r_we    <= ~w_we;
                        r_oe    <= w_we;
                        r_state <= S_ACCESS;
                    end
                end
                S_ACCESS: begin
                    r_cs    <= 1'b1;
                    r_we    <= 1'b1;
                    r_oe    <= 1'b1;
                    r_state <= S_LATCH;
                end
                S_LATCH: begin
                    if (!r_op) begin
                        r_rdata <= bus.ss_data_out;
                    end
                    r_ack   <= r_owner ? 2'b10 : 2'b01;
                    r_state <= S_ACK;
                end
                S_ACK: begin
                    r_ack   <= 2'b00;
                    r_gnt   <= 2'b00;
                    r_busy  <= 1'b0;
                    r_ptr   <= ~r_owner;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.gnt        = r_gnt;
    assign bus.ack        = r_ack;
    assign bus.rdata      = r_rdata;
    assign bus.busy       = r_busy;
    assign bus.ss_cs      = r_cs;
    assign bus.ss_we      = r_we;
    assign bus.ss_oe      = r_oe;
    assign bus.ss_address = r_addr;
    assign bus.ss_data_in = r_din;
endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench for sram_arbiter with a sync_sram model and a scoreboard queue.
// Expected acks/read data are queued at stimulus time and popped on each ack.
module tb_sram_arbiter;
    logic clk = 1'b0;
    logic reset = 1'b1;

    always #5 clk = ~clk;

    sram_arbiter_if #(.ADDR_W(5), .DATA_W(16)) bus ();

    sram_arbiter #(.ADDR_W(5), .DATA_W(16)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    logic [15:0] mem [32];
    logic        clr = 1'b0;
    logic        pl_en = 1'b0;
    logic [4:0]  pl_addr = '0;
    logic [15:0] pl_data = '0;
    logic [15:0] dout = '0;

    assign bus.ss_data_out = dout;

    always @(posedge clk) begin
        if (clr) begin
            for (int i = 0; i < 32; i++) mem[i] <= 16'h0000;
        end else if (pl_en) begin
            mem[pl_addr] <= pl_data;
        end else if (!bus.ss_cs) begin
            if (!bus.ss_we) mem[bus.ss_address] <= bus.ss_data_in;
            if (!bus.ss_oe) dout <= mem[bus.ss_address];
        end
    end

    typedef struct {
        logic [1:0]  ack;
        logic        rd;
        logic [15:0] data;
    } exp_t;

    exp_t        sbq [$];
    exp_t        e;
    logic [15:0] sb_mem [32];
    int          n_checks = 0;
    int          n_err = 0;
    int          wlow = 0;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!bus.ss_cs && !bus.ss_we) wlow++;
        if (bus.ack !== 2'b00) begin
            if (sbq.size() == 0) begin
                chk("unexpected_ack", {30'd0, bus.ack}, 32'd0);
            end else begin
                e = sbq.pop_front();
                chk("sb_ack_owner", {30'd0, bus.ack}, {30'd0, e.ack});
                if (e.rd) chk("sb_rdata", {16'd0, bus.rdata}, {16'd0, e.data});
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input int who, input bit rd,
                            input int a, input logic [15:0] d);
        exp_t x;
        x.ack  = (who == 1) ? 2'b10 : 2'b01;
        x.rd   = rd;
        x.data = 16'h0000;
        if (rd) x.data = sb_mem[a];
        else sb_mem[a] = d;
        sbq.push_back(x);
    endtask

    task automatic wait_ack(input int idx, output int lat);
        lat = 0;
        do begin
            tick();
            lat++;
        end while (bus.ack[idx] !== 1'b1 && lat < 8);
        chk("ack_seen", {31'd0, bus.ack[idx]}, 32'd1);
    endtask

    task automatic do_read(input int who, input int a);
        int lat;
        push_exp(who, 1'b1, a, 16'h0000);
        if (who == 1) begin
            bus.req1 = 1'b1; bus.we1 = 1'b0; bus.addr1 = 5'(a);
        end else begin
            bus.req0 = 1'b1; bus.we0 = 1'b0; bus.addr0 = 5'(a);
        end
        tick();
        chk("rd_oe_low", {31'd0, bus.ss_oe}, 32'd0);
        wait_ack(who, lat);
        chk("rd_latency", 32'(lat + 1), 32'd3);
        bus.req0 = 1'b0;
        bus.req1 = 1'b0;
        tick();
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_gnt"}, {30'd0, bus.gnt}, 32'd0);
        chk({tag, "_ack"}, {30'd0, bus.ack}, 32'd0);
        chk({tag, "_busy"}, {31'd0, bus.busy}, 32'd0);
        chk({tag, "_rdata"}, {16'd0, bus.rdata}, 32'd0);
        chk({tag, "_strobes"}, {29'd0, bus.ss_cs, bus.ss_we, bus.ss_oe}, 32'd7);
    endtask

    initial begin
        int lat;
        int w0;
        logic [1:0] ea;
        bus.req0 = 1'b0; bus.we0 = 1'b0; bus.addr0 = '0; bus.wdata0 = '0;
        bus.req1 = 1'b0; bus.we1 = 1'b0; bus.addr1 = '0; bus.wdata1 = '0;
        for (int i = 0; i < 32; i++) sb_mem[i] = 16'h0000;

        reset = 1'b1;
        clr = 1'b1;
        tick();
        tick();
        clr = 1'b0;
        reset = 1'b0;
        chk_reset_vals("por");
        chk("por_addr", {27'd0, bus.ss_address}, 32'd0);
        chk("por_din", {16'd0, bus.ss_data_in}, 32'd0);

        // single write then read
        w0 = wlow;
        push_exp(0, 1'b0, 5, 16'h00A5);
        bus.req0 = 1'b1; bus.we0 = 1'b1; bus.addr0 = 5'd5; bus.wdata0 = 16'h00A5;
        tick();
        chk("wr_gnt", {30'd0, bus.gnt}, 32'd1);
        chk("wr_strobes", {29'd0, bus.ss_cs, bus.ss_we, bus.ss_oe}, 32'd1);
        chk("wr_busy", {31'd0, bus.busy}, 32'd1);
        wait_ack(0, lat);
        chk("wr_latency", 32'(lat + 1), 32'd3);
        bus.req0 = 1'b0;
        tick();
        chk("wr_strobe_cycles", 32'(wlow - w0), 32'd1);
        chk("wr_idle_busy", {31'd0, bus.busy}, 32'd0);
        do_read(0, 5);

        // contention right after reset: requester 0 first
        reset = 1'b1;
        pl_en = 1'b1; pl_addr = 5'd3; pl_data = 16'h1234;
        sb_mem[3] = 16'h1234;
        tick();
        tick();
        pl_en = 1'b0;
        reset = 1'b0;
        push_exp(0, 1'b1, 5, 16'h0000);
        push_exp(1, 1'b1, 3, 16'h0000);
        bus.req0 = 1'b1; bus.we0 = 1'b0; bus.addr0 = 5'd5;
        bus.req1 = 1'b1; bus.we1 = 1'b0; bus.addr1 = 5'd3;
        tick();
        chk("cont_gnt0", {30'd0, bus.gnt}, 32'd1);
        wait_ack(0, lat);
        bus.req0 = 1'b0;
        wait_ack(1, lat);
        chk("cont_ack1_gap", 32'(lat), 32'd4);
        bus.req1 = 1'b0;
        tick();

        // sustained contention for 16 cycles
        push_exp(0, 1'b1, 5, 16'h0000);
        push_exp(1, 1'b1, 3, 16'h0000);
        push_exp(0, 1'b1, 5, 16'h0000);
        push_exp(1, 1'b1, 3, 16'h0000);
        bus.req0 = 1'b1; bus.req1 = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            tick();
            ea = 2'b00;
            if (k % 4 == 3) ea = ((k / 4) % 2 == 0) ? 2'b01 : 2'b10;
            chk("sus_ack", {30'd0, bus.ack}, {30'd0, ea});
            chk("sus_busy", {31'd0, bus.busy}, {31'd0, (k % 4) != 0});
        end
        bus.req0 = 1'b0; bus.req1 = 1'b0;
        tick();

        // req1 dropped during ACCESS still completes
        push_exp(1, 1'b0, 31, 16'hFFFF);
        bus.req1 = 1'b1; bus.we1 = 1'b1; bus.addr1 = 5'd31; bus.wdata1 = 16'hFFFF;
        tick();
        chk("drop_gnt", {30'd0, bus.gnt}, 32'd2);
        bus.req1 = 1'b0;
        wait_ack(1, lat);
        chk("drop_latency", 32'(lat + 1), 32'd3);
        tick();
        do_read(1, 31);

        // inputs changed during LATCH are ignored
        push_exp(0, 1'b0, 10, 16'h0BEE);
        bus.req0 = 1'b1; bus.we0 = 1'b1; bus.addr0 = 5'd10; bus.wdata0 = 16'h0BEE;
        tick();
        tick();
        bus.addr0 = 5'd11; bus.wdata0 = 16'hDEAD;
        tick();
        chk("stab_addr", {27'd0, bus.ss_address}, 32'd10);
        chk("stab_din", {16'd0, bus.ss_data_in}, 32'h0BEE);
        chk("stab_ack", {30'd0, bus.ack}, 32'd1);
        bus.req0 = 1'b0;
        tick();
        do_read(0, 11);
        do_read(0, 10);

        // reset mid-ACCESS aborts without ack
        bus.req0 = 1'b1; bus.we0 = 1'b1; bus.addr0 = 5'd12; bus.wdata0 = 16'h5555;
        tick();
        chk("rst_in_access", {31'd0, bus.ss_cs}, 32'd0);
        reset = 1'b1;
        bus.req0 = 1'b0;
        tick();
        chk_reset_vals("rst_mid");
        tick();
        reset = 1'b0;
        for (int k = 0; k < 4; k++) tick();
        chk("rst_no_ack_busy", {31'd0, bus.busy}, 32'd0);

        chk("sb_drained", 32'(sbq.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
